// File: rtl/comp_layer_backward.sv
// Backward pass of the compare (argmax) layer: scatters each position's gradient
// into its forward-winning character slot, zero-filling the rest of the map.
module comp_layer_backward #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int N_LEN    = 16,
  parameter int CHAR_LEN = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_backward,
  input  logic [N*CHAR_LEN-1:0]         num,
  input  logic                          run_backward,
  input  logic [N*N_LEN-1:0]            d_backward,
  output logic                          valid_backward,
  output logic [N*CHAR_NUM*N_LEN-1:0]   q_backward
);

  localparam int CNT_W = (N > 1) ? $clog2(N + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      cnt;
  logic [N*CHAR_LEN-1:0] num_reg;
  logic [N*N_LEN-1:0]    d_reg;
  logic                  start, write_row, last_row;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    write_row  = 1'b0;
    last_row   = (cnt == CNT_W'(N - 1));
    case (state)
      IDLE: begin
        if (run_backward) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        if (!run_backward) begin
          state_next = IDLE;
        end else begin
          write_row = 1'b1;
          if (last_row) state_next = DONE;
        end
      end
      DONE: begin
        if (!run_backward) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      num_reg        <= '0;
      d_reg          <= '0;
      q_backward     <= '0;
      valid_backward <= 1'b0;
    end else begin
      if (load_backward && state != RUN) num_reg <= num;
      if (start) begin
        d_reg      <= d_backward;
        q_backward <= '0;
        cnt        <= '0;
      end
      // Out-of-range indices match no column, so such a row is written all zero.
      if (write_row) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt == CNT_W'(i)) begin
            for (int unsigned c = 0; c < CHAR_NUM; c++) begin
              q_backward[(i*CHAR_NUM + c)*N_LEN +: N_LEN] <=
                (num_reg[i*CHAR_LEN +: CHAR_LEN] == CHAR_LEN'(c)) ?
                d_reg[i*N_LEN +: N_LEN] : '0;
            end
          end
        end
        cnt <= cnt + CNT_W'(1);
      end
      valid_backward <= (state_next == DONE);
    end
  end

endmodule

// File: tb/tb_comp_layer_backward.sv
// Directed bench for comp_layer_backward: scatter placement, latency, boundary
// indices, back-to-back runs, abort, mid-run load and reset behaviour.
module tb_comp_layer_backward;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int N_LEN    = 16;
  localparam int CHAR_LEN = 8;
  localparam int MAPW     = N*CHAR_NUM*N_LEN;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   load_backward;
  logic [N*CHAR_LEN-1:0]  num;
  logic                   run_backward;
  logic [N*N_LEN-1:0]     d_backward;
  logic                   valid_backward;
  logic [MAPW-1:0]        q_backward;

  int              total = 0;
  int              bad   = 0;
  int              nums[N];
  logic [15:0]     ds[N];
  logic [MAPW-1:0] exp_q;
  logic [MAPW-1:0] saved_q;

  comp_layer_backward #(.N(N), .CHAR_NUM(CHAR_NUM), .N_LEN(N_LEN), .CHAR_LEN(CHAR_LEN)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_backward (load_backward),
    .num           (num),
    .run_backward  (run_backward),
    .d_backward    (d_backward),
    .valid_backward(valid_backward),
    .q_backward    (q_backward)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < N; i++) begin
      num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(nums[i]);
      d_backward[i*N_LEN +: N_LEN] = ds[i];
    end
  endtask

  // Expected map: zero everywhere, then one value placed per in-range row < rows.
  task automatic build_exp(input int rows);
    exp_q = '0;
    for (int i = 0; i < rows; i++)
      if (nums[i] < CHAR_NUM) exp_q[(i*CHAR_NUM + nums[i])*N_LEN +: N_LEN] = ds[i];
  endtask

  function automatic logic [15:0] get_q(input int i, input int c);
    return q_backward[(i*CHAR_NUM + c)*N_LEN +: N_LEN];
  endfunction

  function automatic int first_diff();
    for (int e = 0; e < N*CHAR_NUM; e++)
      if (q_backward[e*N_LEN +: N_LEN] !== exp_q[e*N_LEN +: N_LEN]) return e;
    return -1;
  endfunction

  task automatic report_map(input string name);
    int e;
    e = first_diff();
    $display("FAIL %s elem(%0d,%0d) got %h want %h", name, e / CHAR_NUM, e % CHAR_NUM,
             q_backward[e*N_LEN +: N_LEN], exp_q[e*N_LEN +: N_LEN]);
  endtask

  // Raises run and steps until valid; lat counts edges after the sampling edge.
  task automatic run_until_valid(output int lat);
    run_backward = 1'b1;
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      step();
      if (valid_backward === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic load_pulse();
    pack_inputs();
    load_backward = 1'b1;
    step();
    load_backward = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_backward = 1'b0; run_backward = 1'b0;
    for (int i = 0; i < N; i++) begin
      num[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'($urandom);
      d_backward[i*N_LEN +: N_LEN] = N_LEN'($urandom);
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 2) rst = 1'b0;
      step();
      total++;
      if (valid_backward !== 1'b0 || q_backward !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d valid got %b want 0, q nonzero", k, valid_backward);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    for (int i = 0; i < N; i++) begin nums[i] = i*20; ds[i] = 16'h0100 + 16'(i); end
    load_pulse();
    run_until_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL basic_latency got %0d want 10", lat); end
    build_exp(N);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("basic_map"); end
    total++;
    if (get_q(3, 60) !== 16'h0103) begin
      bad++; $display("FAIL basic_elem(3,60) got %h want 0103", get_q(3, 60));
    end
    saved_q = q_backward;
    run_backward = 1'b0;
    step();
    total++;
    if (valid_backward !== 1'b0) begin bad++; $display("FAIL basic_drop_valid got %b want 0", valid_backward); end
    total++;
    if (q_backward !== saved_q) begin bad++; $display("FAIL basic_drop_hold q changed after drop"); end
  endtask

  // Load and run in the same IDLE cycle; the run must use the new indices.
  task automatic test_boundary();
    int lat;
    nums = '{0, 17, 100, 150, 3, 200, 255, 198, 1, 199};
    ds   = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h7FFF,
             16'hFFFF, 16'h8000, 16'h0001, 16'hFFFF, 16'hFFFF};
    pack_inputs();
    load_backward = 1'b1;
    run_backward  = 1'b1;
    step();
    load_backward = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (valid_backward === 1'b1) begin lat = k; break; end
    end
    total++;
    if (lat !== 10) begin bad++; $display("FAIL bound_latency got %0d want 10", lat); end
    total++;
    if (get_q(0, 0) !== 16'h8000) begin bad++; $display("FAIL bound_elem(0,0) got %h want 8000", get_q(0, 0)); end
    total++;
    if (get_q(9, 199) !== 16'hFFFF) begin bad++; $display("FAIL bound_elem(9,199) got %h want ffff", get_q(9, 199)); end
    total++;
    if (q_backward[5*CHAR_NUM*N_LEN +: 2*CHAR_NUM*N_LEN] !== '0) begin
      bad++; $display("FAIL bound_rows56 got nonzero want all zero");
    end
    build_exp(N);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("bound_map"); end
  endtask

  task automatic test_back_to_back();
    int lat;
    saved_q = q_backward;
    nums = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    load_pulse();
    total++;
    if (valid_backward !== 1'b1 || q_backward !== saved_q) begin
      bad++; $display("FAIL b2b_done_hold valid got %b want 1 (or q moved)", valid_backward);
    end
    run_backward = 1'b0;
    step();
    total++;
    if (valid_backward !== 1'b0) begin bad++; $display("FAIL b2b_drop got %b want 0", valid_backward); end
    for (int i = 0; i < N; i++) ds[i] = 16'h1230 + 16'(i);
    pack_inputs();
    run_until_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL b2b_latency got %0d want 10", lat); end
    build_exp(N);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("b2b_map"); end
    run_backward = 1'b0;
    step();
  endtask

  task automatic test_abort();
    int lat;
    logic seen;
    nums = '{199, 0, 50, 51, 52, 53, 54, 55, 56, 57};
    for (int i = 0; i < N; i++) ds[i] = 16'hA000 + 16'(i);
    load_pulse();
    run_backward = 1'b1;
    seen = 1'b0;
    step();
    for (int k = 1; k <= 4; k++) begin step(); seen = seen | (valid_backward === 1'b1); end
    run_backward = 1'b0;
    for (int k = 0; k < 3; k++) begin step(); seen = seen | (valid_backward === 1'b1); end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_valid got 1 want 0"); end
    build_exp(4);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("abort_partial"); end
    run_until_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL abort_restart_latency got %0d want 10", lat); end
    build_exp(N);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("abort_restart_map"); end
    run_backward = 1'b0;
    step();
    // Different indices pulsed mid-run must not reach the result.
    run_backward = 1'b1;
    lat = -1;
    for (int k = 0; k <= 20; k++) begin
      load_backward = (k == 3);
      if (k == 3) num = ~num;
      step();
      if (valid_backward === 1'b1) begin lat = k; break; end
    end
    load_backward = 1'b0;
    total++;
    if (lat !== 10) begin bad++; $display("FAIL midload_latency got %0d want 10", lat); end
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("midload_map"); end
    run_backward = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    nums = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    for (int i = 0; i < N; i++) ds[i] = 16'h0F00 + 16'(i);
    pack_inputs();
    load_backward = 1'b1;
    run_backward  = 1'b1;
    step();
    load_backward = 1'b0;
    for (int k = 1; k <= 6; k++) step();
    rst = 1'b1;
    run_backward = 1'b0;
    step();
    total++;
    if (valid_backward !== 1'b0 || q_backward !== '0) begin
      bad++; $display("FAIL rstmid_clear valid got %b want 0, q want zero", valid_backward);
    end
    rst = 1'b0;
    // Latched indices were cleared, so an unloaded run lands every row in column 0.
    run_until_valid(lat);
    for (int i = 0; i < N; i++) nums[i] = 0;
    build_exp(N);
    total++;
    if (lat !== 10 || q_backward !== exp_q) begin
      bad++; $display("FAIL rstmid_numclr latency got %0d want 10 (or map wrong)", lat);
    end
    run_backward = 1'b0;
    step();
    nums = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    load_pulse();
    run_until_valid(lat);
    total++;
    if (lat !== 10) begin bad++; $display("FAIL rstmid_rerun_latency got %0d want 10", lat); end
    build_exp(N);
    total++;
    if (q_backward !== exp_q) begin bad++; report_map("rstmid_rerun_map"); end
    run_backward = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp_layer_backward.md
Name: comp_layer_backward

Overview:
- Backward-pass counterpart of the forward compare (argmax) layer.
- Forward produces, per position, the winning character index (num) and its value (q). This block does the reverse: it scatters each position's incoming gradient into the winning character slot of an N x CHAR_NUM gradient map and zero-fills every other slot.
- Sits between the downstream layer's backward output and the upstream layer's backward input, in the S2/S3 training phases.
- Processes one position per cycle under a run/valid handshake matching the forward layer's.

Parameters:
- N, 10: positions per sample.
- CHAR_NUM, 200: characters per position (row length).
- N_LEN, 16: gradient/data word width, two's complement fixed point.
- CHAR_LEN, 8: index width. ceil(log2(CHAR_NUM)) <= CHAR_LEN.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_backward  in  1  one-cycle pulse; latch num.
- num  in  N*CHAR_LEN  forward argmax indices; position i at [i*CHAR_LEN +: CHAR_LEN].
- run_backward  in  1  level request; held high until valid_backward is seen, then dropped.
- d_backward  in  N*N_LEN  gradient per position; position i at [i*N_LEN +: N_LEN].
- valid_backward  out  1  result complete; held while run_backward stays high.
- q_backward  out  N*CHAR_NUM*N_LEN  gradient map; element (i,c) at [(i*CHAR_NUM+c)*N_LEN +: N_LEN].

Behaviour:
- Reset (rst=1 at a clock edge, any state, including mid-RUN):
  - state=IDLE, row counter=0.
  - valid_backward=0, q_backward=0, latched num=0, latched d=0.
- State machine IDLE -> RUN -> DONE.
- Index latch (num_reg):
  - load_backward=1 in IDLE or DONE: num_reg<=num.
  - load_backward in RUN: ignored.
- IDLE:
  - run_backward=1 sampled at edge E0: d_reg<=d_backward, q_backward<=0, cnt<=0, state->RUN.
  - Otherwise hold all outputs.
- RUN, at edge E(k+1), k=0..N-1:
  - Row k of q_backward is written: slot num_reg[k] = d_reg[k]; all other slots of row k = 0.
  - If num_reg[k] >= CHAR_NUM, row k is written all zero. No wrap, no clamp.
  - After row N-1 (edge EN): state->DONE, valid_backward<=1 at the same edge.
- Latency: valid_backward rises at edge EN, i.e. N cycles after the sampling edge E0.
- Data is captured only at E0: d_backward changes during RUN have no effect.
- DONE:
  - valid_backward=1 and q_backward stable while run_backward=1.
  - run_backward=0 sampled: state->IDLE, valid_backward<=0. q_backward is retained until the next run.
- Abort: run_backward=0 sampled in RUN -> IDLE, valid_backward stays 0, q_backward keeps its partially written rows.
- Simultaneous load_backward and run_backward in IDLE: num_reg takes the new num at that edge, and the run uses the new value.
- Arithmetic: pure routing. No sign change, no accumulation, no saturation. Values pass bit-exact.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset and idle check:
   - Stimulus: rst=1 for 2 cycles, then release; run_backward=0, random num/d_backward.
   - Required: valid_backward=0 and q_backward=0 throughout.
2. Basic scatter:
   - Stimulus: load_backward pulse with num[i]=i*20 (i=0..9); d_backward[i]=16'h0100+i; run_backward=1 held.
   - Required: valid_backward rises exactly 10 cycles after run is sampled. q(i,20i)=16'h0100+i; all other 1990 elements are 0.
   - Then drop run: valid_backward=0 next edge, q_backward unchanged.
3. Boundary indices and signed values:
   - Stimulus: num[0]=0, num[9]=199, num[5]=200, num[6]=255; d=16'h8000 and 16'hFFFF mixed.
   - Required: slots (0,0) and (9,199) carry their values bit-exact; rows 5 and 6 are entirely zero.
4. Back-to-back runs:
   - Stimulus: second run with a new num (loaded in DONE before dropping run) and a new d, following the forward-layer sequence (load, run, wait valid, drop).
   - Required: the result contains only the new scatter; no residue of the first run.
5. Abort and mid-run effects:
   - Stimulus: drop run_backward after 4 RUN cycles, then restart with identical inputs. Separately, pulse load_backward mid-RUN with a different num.
   - Required: no valid_backward during the aborted run. Restart yields the full correct map. The mid-RUN load is ignored (the result uses the old num).
6. Reset mid-operation:
   - Stimulus: assert rst at RUN cycle 7.
   - Required: next edge valid_backward=0 and q_backward=0. A subsequent normal run completes correctly in 10 cycles.
